// File: rtl/musb_bus_arbiter_4.sv
// ---------------------------------------------------------------------------
// musb_bus_arbiter_4
//   Round-robin arbiter that gives four bus masters turns at one shared slave.
//   A grant is held until the slave acknowledges, the master drops its
//   request, or the grant has been held for TIMEOUT cycles, whichever comes
//   first. When a grant is released, the next requester is picked in the
//   same cycle, so there is no idle gap between masters.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req[3:0]   in   per-master request, held until the transfer completes
//   slave_ack  in   one-cycle completion pulse from the shared slave
//   grant[3:0] out  one-hot grant (zero when idle)
//   select[1:0]out  index of the granted master (last winner while idle)
//   bus_valid  out  |grant
//   timeout    out  one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module musb_bus_arbiter_4 #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       slave_ack,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       bus_valid,
    output logic       timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;

    logic [3:0] cand;
    logic [3:0] rot;
    logic [1:0] off;
    logic [1:0] win;
    logic       any;
    logic       cnt_hit;
    logic       rel;

    // In BUSY the current owner is excluded from re-arbitration. It is the
    // lowest-priority slot anyway (ptr already points past it); the mask
    // forces at least one IDLE cycle if it is the only requester left.
    assign cand = (state == BUSY) ? (req & ~grant) : req;
    assign any  = |cand;

    // Rotate so that rot[0] is the requester at ptr, rot[1] at ptr+1, ...
    always_comb begin
        rot = cand;
        case (ptr)
            2'd0: rot = cand;
            2'd1: rot = {cand[0],   cand[3:1]};
            2'd2: rot = {cand[1:0], cand[3:2]};
            2'd3: rot = {cand[2:0], cand[3]};
            default: rot = cand;
        endcase
    end

    always_comb begin
        off = 2'd3;
        if      (rot[0]) off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else             off = 2'd3;
    end

    assign win     = ptr + off;
    assign cnt_hit = (cnt == CW'(TIMEOUT - 1));
    assign rel     = slave_ack | ~req[select] | cnt_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= 4'b0000;
            select    <= 2'd0;
            bus_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 2'd0;
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // slave_ack is ignored here; select keeps the last winner
                    if (any) begin
                        state     <= BUSY;
                        grant     <= 4'b0001 << win;
                        select    <= win;
                        bus_valid <= 1'b1;
                        ptr       <= win + 2'd1;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        // Only a genuine forced release pulses timeout: an ack
                        // or a dropped request in the same cycle is a normal
                        // completion.
                        timeout <= cnt_hit & ~slave_ack & req[select];
                        if (any) begin
                            grant  <= 4'b0001 << win;
                            select <= win;
                            ptr    <= win + 2'd1;
                            cnt    <= '0;
                        end else begin
                            state     <= IDLE;
                            grant     <= 4'b0000;
                            bus_valid <= 1'b0;
                        end
                    end else begin
                        // cnt_hit always releases, so this never wraps
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_musb_bus_arbiter_4.sv
module tb_musb_bus_arbiter_4;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       slave_ack = 1'b0;
    logic [3:0] grant;
    logic [1:0] select;
    logic       bus_valid;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int         m_g;     // granted master, -1 when none
    int         m_ptr;   // first master in priority order
    int         m_held;  // cycles the current grant has been visible
    int         m_sel;
    logic [3:0] exp_grant;
    logic [1:0] exp_sel;
    logic       exp_to;

    musb_bus_arbiter_4 #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .slave_ack (slave_ack),
        .grant     (grant),
        .select    (select),
        .bus_valid (bus_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_outs();
        exp_grant = (m_g < 0) ? 4'b0000 : (4'b0001 << m_g);
        exp_sel   = 2'(m_sel);
    endtask

    task automatic model_reset();
        m_g = -1; m_ptr = 0; m_held = 0; m_sel = 0; exp_to = 1'b0;
        model_outs();
    endtask

    task automatic model_grant(input int w);
        m_g = w; m_sel = w; m_ptr = (w + 1) % 4; m_held = 1;
    endtask

    // One clock: model consumes the inputs that the edge will sample.
    task automatic cyc();
        int  w;
        bit  done, forced;
        exp_to = 1'b0;
        if (m_g < 0) begin
            w = pick(req, -1);
            if (w >= 0) model_grant(w);
        end else begin
            done   = slave_ack || !req[m_g];
            forced = (m_held >= TO);
            if (done || forced) begin
                exp_to = forced && !done;
                w = pick(req, m_g);
                if (w >= 0) model_grant(w);
                else m_g = -1;
            end else begin
                m_held++;
            end
        end
        model_outs();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req = 4'b0000; slave_ack = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        n_chk++; if (select !== 2'd0) begin n_fail++; $display("FAIL reset_select got=%0d exp=0", select); end
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid got=%b exp=0", bus_valid); end
        n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    endtask

    // req=1111 held, ack on every 3rd cycle of each grant
    task automatic test_round_robin();
        logic [3:0] seq_g[$];
        logic [1:0] seq_s[$];
        logic [3:0] want_g[5];
        logic [1:0] want_s[5];
        logic [3:0] last;
        bit gap;
        want_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        want_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; slave_ack = 1'b0;
        last = 4'b0000; gap = 0;
        for (int c = 0; c < 15; c++) begin
            slave_ack = (m_g >= 0 && m_held == 3);
            cyc();
            n_chk++; if (grant !== exp_grant) begin n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, grant, exp_grant); end
            if (c > 0 && bus_valid !== 1'b1) gap = 1;
            if (grant !== last) begin seq_g.push_back(grant); seq_s.push_back(select); end
            last = grant;
        end
        n_chk++; if (gap) begin n_fail++; $display("FAIL rr_back_to_back got=gap exp=no_gap"); end
        n_chk++; if (seq_g.size() < 5) begin n_fail++; $display("FAIL rr_count got=%0d exp=5", seq_g.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++; if (seq_g[i] !== want_g[i] || seq_s[i] !== want_s[i]) begin
                    n_fail++; $display("FAIL rr_seq idx=%0d got=%b/%0d exp=%b/%0d", i, seq_g[i], seq_s[i], want_g[i], want_s[i]);
                end
            end
        end
        slave_ack = 1'b0;
        go_idle();
    endtask

    task automatic test_single_master();
        req = 4'b0100;
        cyc();
        n_chk++; if (grant !== 4'b0100 || select !== 2'd2) begin n_fail++; $display("FAIL single_grant got=%b/%0d exp=0100/2", grant, select); end
        cyc();
        slave_ack = 1'b1;
        cyc();
        slave_ack = 1'b0; req = 4'b0000;
        n_chk++; if (grant !== 4'b0000 || select !== 2'd2 || bus_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_release got=%b/%0d/%b exp=0000/2/0", grant, select, bus_valid);
        end
        // ptr is now 3, so master 3 beats master 0
        req = 4'b1001;
        cyc();
        n_chk++; if (grant !== 4'b1000 || grant !== exp_grant) begin n_fail++; $display("FAIL single_ptr3 got=%b exp=1000", grant); end
        go_idle();
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_chk++; if (grant !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL to_hold cyc=%0d got=%b/%b exp=0001/0", c, grant, timeout);
            end
        end
        cyc();
        n_chk++; if (grant !== 4'b0000 || timeout !== 1'b1 || exp_to !== 1'b1) begin
            n_fail++; $display("FAIL to_release got=%b/%b exp=0000/1", grant, timeout);
        end
        cyc();
        n_chk++; if (grant !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_regrant got=%b/%b exp=0001/0", grant, timeout);
        end
        go_idle();
    endtask

    task automatic test_req_drop();
        req = 4'b0010;
        cyc();
        req = 4'b1010;
        cyc();
        n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL drop_hold got=%b exp=0010", grant); end
        req = 4'b1000;
        cyc();
        n_chk++; if (grant !== 4'b1000 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL drop_switch got=%b/%b exp=1000/0", grant, timeout);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        req = 4'b0010;
        cyc();
        n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL areset_pre got=%b exp=0010", grant); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (grant !== 4'b0000 || select !== 2'd0 || bus_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL areset_now got=%b/%0d/%b/%b exp=0000/0/0/0", grant, select, bus_valid, timeout);
        end
        model_reset();
        req = 4'b0110;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        n_chk++; if (grant !== 4'b0010 || select !== 2'd1 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL areset_first got=%b/%0d/%b exp=0010/1/0", grant, select, timeout);
        end
        go_idle();
    endtask

    task automatic test_idle_ack();
        logic [1:0] sel0;
        sel0 = select;
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            slave_ack = 1'b1;
            cyc();
            n_chk++; if (grant !== 4'b0000 || bus_valid !== 1'b0 || select !== sel0 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL idle_ack cyc=%0d got=%b/%b/%0d/%b exp=0000/0/%0d/0", c, grant, bus_valid, select, timeout, sel0);
            end
        end
        slave_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            slave_ack = ($urandom_range(0, 5) == 0);
            cyc();
            n_chk++; if (grant !== exp_grant || select !== exp_sel || bus_valid !== (m_g >= 0) || timeout !== exp_to) begin
                n_fail++; $display("FAIL rand cyc=%0d got=%b/%0d/%b/%b exp=%b/%0d/%b/%b", c, grant, select, bus_valid, timeout,
                                   exp_grant, exp_sel, (m_g >= 0), exp_to);
            end
            n_chk++; if (!$onehot0(grant)) begin n_fail++; $display("FAIL rand_onehot cyc=%0d got=%b exp=onehot0", c, grant); end
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b0;
                #1;
                n_chk++; if (grant !== 4'b0000 || timeout !== 1'b0) begin
                    n_fail++; $display("FAIL rand_reset cyc=%0d got=%b/%b exp=0000/0", c, grant, timeout);
                end
                model_reset();
                #1 rst = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_single_master();
        test_timeout();
        test_req_drop();
        test_async_reset();
        test_idle_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/musb_bus_arbiter_4.md
MUSB_BUS_ARBITER_4 -- requirements
Module: musb_bus_arbiter_4

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max granted cycles without completion before forced release (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  per-master request; bit i held high by master i until its transfer completes.
REQ-005 SHALL have port slave_ack  input  1  one-cycle pulse from shared slave marking completion of current transfer.
REQ-006 SHALL have port grant  output  4  one-hot (or zero) grant to masters.
REQ-007 SHALL have port select  output  2  index of granted master; drives the select input of the shared 4:1 bus mux.
REQ-008 SHALL have port bus_valid  output  1  high exactly when grant is nonzero.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is force-released.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (one grant held); all outputs registered.
REQ-011 SHALL keep a 2-bit round-robin pointer ptr; priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 In IDLE, if req nonzero at edge N, SHALL enter BUSY with grant of highest-priority requester visible after edge N (one-cycle latency); else stay IDLE.
REQ-013 On entering BUSY with winner w, SHALL set select=w, ptr=w+1 mod 4 (wrap 3->0), clear timeout counter.
REQ-014 In BUSY, grant and select SHALL stay constant until a release event: slave_ack=1, req[w]=0, or counter reaching TIMEOUT-1.
REQ-015 On release at edge N, SHALL re-arbitrate in the same cycle over req with bit w masked; if any remain, grant the new winner after edge N (back-to-back, no idle gap); else go IDLE with grant=0.
REQ-016 Masked bit w SHALL be eligible again from the next arbitration; if w is sole requester after release, one IDLE cycle SHALL occur before re-granting w.
REQ-017 Counter SHALL increment each BUSY cycle without release, width ceil(log2(TIMEOUT)) bits, never wrapping.
REQ-018 Timeout release SHALL pulse timeout=1 for exactly one cycle, coincident with the first cycle of the following state.
REQ-019 Simultaneous slave_ack and timeout condition SHALL be treated as ack: timeout stays 0.
REQ-020 slave_ack while IDLE SHALL be ignored.
REQ-021 select SHALL hold last granted index while IDLE (mux input stable); bus_valid SHALL equal |grant.
REQ-022 grant SHALL never have more than one bit set.

Reset
REQ-023 rst=0 SHALL immediately force grant=0, select=0, bus_valid=0, timeout=0, ptr=0, counter=0, state IDLE, independent of clk.
REQ-024 Reset asserted mid-transfer SHALL drop grant without timeout pulse; after rst deasserts, first arbitration SHALL start with ptr=0.
REQ-025 First clk edge after rst release SHALL be able to issue a grant (no extra dead cycles).

Verification
REQ-026 Reset, req=4'b1111 held, ack every 3rd BUSY cycle -> grants 0001,0010,0100,1000,0001 in order, select 0,1,2,3,0, back-to-back.
REQ-027 req=4'b0100 only, ack after 2 cycles -> grant 0100 one cycle after req, select=2, then grant=0 with select still 2, ptr=3.
REQ-028 TIMEOUT=4, req=4'b0001, no ack -> grant 0001 for 4 cycles, then grant=0 with timeout=1 for one cycle; req still high -> re-grant 0001 one cycle later.
REQ-029 Granted master 1 drops req mid-transfer while req[3]=1 -> grant 1000 on next cycle, timeout=0.
REQ-030 rst pulsed low asynchronously between edges while grant=0010 -> grant=0 immediately; after release with req=4'b0110 -> grant 0010 (ptr=0 order).
REQ-031 slave_ack pulses while IDLE with req=0 -> outputs unchanged, grant remains 0.
